// File: rtl/elevator_call_panel.sv
// ---------------------------------------------------------------------------
// elevator_call_panel
//
// Hall-call front end for an elevator controller. Raw call buttons are
// synchronized and debounced. Each qualified press latches a per-floor call.
// A small issuer FSM then hands pending calls to the controller one at a
// time, in round-robin floor order. A call is retired when the door opens
// at that floor.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   buttons[15:0]  raw asynchronous call buttons, bit f = floor f (bit 0 unused)
//   current_floor  floor the car is at now
//   door_open      door-open indication from the controller
//   req_floor      one-cycle floor request to the controller, 0 when idle
//   call_lamps     bit f lit while floor f has a pending or issued call
//   outstanding    number of calls issued but not yet serviced
// ---------------------------------------------------------------------------
module elevator_call_panel #(
    parameter int DEBOUNCE_CYCLES = 4,   // 1..31
    parameter int MAX_OUTSTANDING = 8    // 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] buttons,
    input  logic [3:0]  current_floor,
    input  logic        door_open,
    output logic [3:0]  req_floor,
    output logic [15:0] call_lamps,
    output logic [3:0]  outstanding
);

    typedef enum logic [1:0] {
        CALL_IDLE,
        CALL_PENDING,
        CALL_ISSUED
    } call_state_t;

    typedef enum logic [1:0] {
        ISS_SCAN,
        ISS_ISSUE,
        ISS_GAP
    } iss_state_t;

    localparam logic [4:0] DB_LIMIT  = 5'(DEBOUNCE_CYCLES);
    localparam logic [3:0] OUT_LIMIT = 4'(MAX_OUTSTANDING);

    // Input conditioning
    logic [15:1] sync_meta;
    logic [15:1] sync_q;
    logic [4:0]  db_cnt [1:15];
    logic [15:1] press_evt;

    // Per-floor call tracking (entry 0 is held IDLE permanently so that
    // any 4-bit floor code can index the array directly)
    call_state_t call_state      [0:15];
    call_state_t call_state_next [0:15];
    logic [15:0] call_lamps_next;

    // Issuer
    iss_state_t  iss_state;
    iss_state_t  iss_state_next;
    logic [3:0]  sel_floor;
    logic [3:0]  last_issued;
    logic [3:0]  pick_floor;
    logic        pick_valid;
    logic [4:0]  rr_cand;
    logic [3:0]  req_floor_next;
    logic        issue_fire;

    // Service
    logic        door_q;
    logic        svc_evt;
    logic        cnt_inc;
    logic        cnt_dec;

    // Floor code 0 means "no request", so its button is never looked at.
    logic        unused_button0;
    assign unused_button0 = buttons[0];

    // -----------------------------------------------------------------------
    // Synchronizer and debounce
    // press_evt is registered so that it is high in exactly the cycle in
    // which db_cnt first shows DEBOUNCE_CYCLES. The counter saturates there,
    // so the event cannot repeat until the button drops and re-qualifies.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
            press_evt <= '0;
            // NOTE: the counter array is explicitly reset. A held button must
            // fully re-qualify after reset, and stale counts would let it skip
            // part of the debounce.
            for (int f = 1; f <= 15; f++) begin
                db_cnt[f] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here. Each flop samples its
            // pre-edge input, which keeps the two synchronizer stages distinct.
            sync_meta <= buttons[15:1];
            sync_q    <= sync_meta;
            for (int f = 1; f <= 15; f++) begin
                press_evt[f] <= sync_q[f] && (db_cnt[f] == DB_LIMIT - 5'd1);
                if (!sync_q[f]) begin
                    db_cnt[f] <= '0;
                end else if (db_cnt[f] != DB_LIMIT) begin
                    db_cnt[f] <= db_cnt[f] + 5'd1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Service detection: the door_open rising edge at a real floor
    // -----------------------------------------------------------------------
    assign svc_evt = door_open && !door_q && (current_floor != 4'd0);

    // -----------------------------------------------------------------------
    // Round-robin pick: the first PENDING floor after last_issued, wrapping
    // 15 -> 1. last_issued is always in 1..15, so the candidate sum stays in
    // 2..30 and one subtraction folds it back into 1..15.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before any branch, so that no
        // path through the block can hold a stale value (no latch).
        pick_valid = 1'b0;
        pick_floor = 4'd0;
        rr_cand    = 5'd0;
        for (int i = 1; i <= 15; i++) begin
            rr_cand = {1'b0, last_issued} + 5'(i);
            if (rr_cand > 5'd15) begin
                rr_cand = rr_cand - 5'd15;
            end
            if (!pick_valid && call_state[rr_cand[3:0]] == CALL_PENDING) begin
                pick_valid = 1'b1;
                pick_floor = rr_cand[3:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Issuer FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_state   <= ISS_SCAN;
            sel_floor   <= 4'd0;
            last_issued <= 4'd15;
            req_floor   <= 4'd0;
        end else begin
            iss_state <= iss_state_next;
            req_floor <= req_floor_next;
            if (iss_state == ISS_SCAN && iss_state_next == ISS_ISSUE) begin
                sel_floor   <= pick_floor;
                last_issued <= pick_floor;
            end
        end
    end

    // Issuer FSM: next state
    always_comb begin
        iss_state_next = iss_state;
        unique case (iss_state)
            ISS_SCAN: begin
                if (pick_valid && (outstanding < OUT_LIMIT)) begin
                    iss_state_next = ISS_ISSUE;
                end
            end
            ISS_ISSUE: iss_state_next = ISS_GAP;
            ISS_GAP:   iss_state_next = ISS_SCAN;
            default:   iss_state_next = ISS_SCAN;
        endcase
    end

    // Issuer FSM: outputs
    // req_floor is loaded on the SCAN->ISSUE edge, so it is nonzero exactly
    // during the ISSUE cycle. The call is committed at the end of that cycle.
    // If the floor was serviced between selection and ISSUE, the commit is
    // dropped so that the count and the lamp stay truthful.
    always_comb begin
        req_floor_next = 4'd0;
        issue_fire     = 1'b0;
        if (iss_state == ISS_SCAN && iss_state_next == ISS_ISSUE) begin
            req_floor_next = pick_floor;
        end
        if (iss_state == ISS_ISSUE && call_state[sel_floor] == CALL_PENDING) begin
            issue_fire = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Per-floor call state. Priority rises down the list, so a service
    // overrides both a same-cycle press and a same-cycle issue.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int f = 0; f <= 15; f++) begin
            call_state_next[f] = call_state[f];
        end
        for (int f = 1; f <= 15; f++) begin
            if (press_evt[f] && call_state[f] == CALL_IDLE) begin
                call_state_next[f] = CALL_PENDING;
            end
            if (issue_fire && sel_floor == 4'(f)) begin
                call_state_next[f] = CALL_ISSUED;
            end
            if (svc_evt && current_floor == 4'(f)) begin
                call_state_next[f] = CALL_IDLE;
            end
        end
        call_state_next[0] = CALL_IDLE;

        call_lamps_next = 16'd0;
        for (int f = 1; f <= 15; f++) begin
            call_lamps_next[f] = (call_state_next[f] != CALL_IDLE);
        end
    end

    // An issue that is serviced in the same cycle never becomes ISSUED, so it
    // does not count. Only a service of an ISSUED floor decrements. Because of
    // this pairing the counter tracks the number of ISSUED floors exactly,
    // and it can neither wrap nor exceed the SCAN-side limit.
    assign cnt_inc = issue_fire && !(svc_evt && current_floor == sel_floor);
    assign cnt_dec = svc_evt && (call_state[current_floor] == CALL_ISSUED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            door_q      <= 1'b0;
            call_lamps  <= 16'd0;
            outstanding <= 4'd0;
            for (int f = 0; f <= 15; f++) begin
                call_state[f] <= CALL_IDLE;
            end
        end else begin
            door_q     <= door_open;
            call_lamps <= call_lamps_next;
            for (int f = 0; f <= 15; f++) begin
                call_state[f] <= call_state_next[f];
            end
            if (cnt_inc && !cnt_dec) begin
                outstanding <= outstanding + 4'd1;
            end else if (cnt_dec && !cnt_inc) begin
                outstanding <= outstanding - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_elevator_call_panel.sv
// ---------------------------------------------------------------------------
// tb_elevator_call_panel
//
// Directed bench for elevator_call_panel. Instance "dut" uses the default
// parameters. Instance "dut_b" uses MAX_OUTSTANDING=2 to exercise the
// stall. Inputs change and outputs are sampled on the falling edge. The
// loop index k counts rising edges since the stimulus was applied.
// ---------------------------------------------------------------------------
module tb_elevator_call_panel;

    logic        clk = 1'b0;
    logic        reset;

    logic [15:0] buttons;
    logic [3:0]  current_floor;
    logic        door_open;
    logic [3:0]  req_floor;
    logic [15:0] lamps;
    logic [3:0]  outst;

    logic [15:0] buttons_b;
    logic [3:0]  floor_b;
    logic        door_b;
    logic [3:0]  req_b;
    logic [15:0] lamps_b;
    logic [3:0]  outst_b;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    elevator_call_panel dut (
        .clk           (clk),
        .reset         (reset),
        .buttons       (buttons),
        .current_floor (current_floor),
        .door_open     (door_open),
        .req_floor     (req_floor),
        .call_lamps    (lamps),
        .outstanding   (outst)
    );

    elevator_call_panel #(.DEBOUNCE_CYCLES(4), .MAX_OUTSTANDING(2)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .buttons       (buttons_b),
        .current_floor (floor_b),
        .door_open     (door_b),
        .req_floor     (req_b),
        .call_lamps    (lamps_b),
        .outstanding   (outst_b)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        buttons       = 16'd0;
        current_floor = 4'd0;
        door_open     = 1'b0;
        buttons_b     = 16'd0;
        floor_b       = 4'd0;
        door_b        = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    // Reset values hold even with every button pressed during reset.
    task automatic test_reset();
        reset   = 1'b1;
        buttons = 16'hFFFF;
        step(8);
        tests_run++;
        if (req_floor !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_req: got %0d expected 0", req_floor);
        end
        tests_run++;
        if (lamps !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_lamps: got %h expected 0000", lamps);
        end
        tests_run++;
        if (outst !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_outstanding: got %0d expected 0", outst);
        end
        apply_reset();
    endtask

    // Floor 5 held 10 cycles: lamp at edge 7, request at edge 8, count at edge 9.
    task automatic test_press_latency();
        logic [15:0] exp_lamps;
        logic [3:0]  exp_req;
        logic [3:0]  exp_out;
        apply_reset();
        buttons[5] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_lamps = (k >= 7) ? 16'h0020 : 16'h0000;
            exp_req   = (k == 8) ? 4'd5 : 4'd0;
            exp_out   = (k >= 9) ? 4'd1 : 4'd0;
            tests_run++;
            if (lamps !== exp_lamps) begin
                tests_failed++;
                $display("FAIL latency_lamps k=%0d: got %h expected %h", k, lamps, exp_lamps);
            end
            tests_run++;
            if (req_floor !== exp_req) begin
                tests_failed++;
                $display("FAIL latency_req k=%0d: got %0d expected %0d", k, req_floor, exp_req);
            end
            tests_run++;
            if (outst !== exp_out) begin
                tests_failed++;
                $display("FAIL latency_outstanding k=%0d: got %0d expected %0d", k, outst, exp_out);
            end
            if (k == 10) buttons[5] = 1'b0;
        end
    endtask

    // A 3-cycle glitch is rejected. A 4-cycle pulse is exactly enough.
    task automatic test_glitch();
        logic [15:0] exp_lamps;
        apply_reset();
        buttons[3] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            tests_run++;
            if (lamps !== 16'd0 || req_floor !== 4'd0) begin
                tests_failed++;
                $display("FAIL glitch_rejected k=%0d: got lamps=%h req=%0d expected 0000/0", k, lamps, req_floor);
            end
            if (k == 3) buttons[3] = 1'b0;
        end
        apply_reset();
        buttons[3] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 4) buttons[3] = 1'b0;
            if (k >= 6) begin
                exp_lamps = (k == 7) ? 16'h0008 : 16'h0000;
                tests_run++;
                if (lamps !== exp_lamps) begin
                    tests_failed++;
                    $display("FAIL min_pulse_lamps k=%0d: got %h expected %h", k, lamps, exp_lamps);
                end
            end
        end
    endtask

    // With last_issued=9, floors 2/9/14 are issued in the order 14, 2, 9.
    task automatic test_round_robin();
        logic [3:0] exp_req;
        apply_reset();
        buttons[9] = 1'b1;
        step(10);
        buttons[9] = 1'b0;
        step(1);
        tests_run++;
        if (outst !== 4'd1 || lamps !== 16'h0200) begin
            tests_failed++;
            $display("FAIL rr_setup_issue9: got out=%0d lamps=%h expected 1/0200", outst, lamps);
        end
        current_floor = 4'd9;
        door_open     = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outst !== 4'd0 || lamps !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rr_setup_service9: got out=%0d lamps=%h expected 0/0000", outst, lamps);
        end
        door_open     = 1'b0;
        current_floor = 4'd0;
        step(4);
        buttons = 16'h4204;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            case (k)
                8:       exp_req = 4'd14;
                11:      exp_req = 4'd2;
                14:      exp_req = 4'd9;
                default: exp_req = 4'd0;
            endcase
            tests_run++;
            if (req_floor !== exp_req) begin
                tests_failed++;
                $display("FAIL rr_order k=%0d: got %0d expected %0d", k, req_floor, exp_req);
            end
            if (k == 7) begin
                tests_run++;
                if (lamps !== 16'h4204) begin
                    tests_failed++;
                    $display("FAIL rr_lamps: got %h expected 4204", lamps);
                end
            end
            if (k == 10) buttons = 16'd0;
        end
        tests_run++;
        if (outst !== 4'd3) begin
            tests_failed++;
            $display("FAIL rr_outstanding: got %0d expected 3", outst);
        end
    endtask

    // MAX_OUTSTANDING=2: floor 3 waits until a service frees a slot.
    task automatic test_max_outstanding();
        logic [3:0] exp_req;
        apply_reset();
        buttons_b = 16'h000E;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_req = (k == 8) ? 4'd1 : (k == 11) ? 4'd2 : 4'd0;
            tests_run++;
            if (req_b !== exp_req) begin
                tests_failed++;
                $display("FAIL max_out_req k=%0d: got %0d expected %0d", k, req_b, exp_req);
            end
            if (k == 10) buttons_b = 16'd0;
        end
        tests_run++;
        if (outst_b !== 4'd2 || lamps_b !== 16'h000E) begin
            tests_failed++;
            $display("FAIL max_out_stall: got out=%0d lamps=%h expected 2/000E", outst_b, lamps_b);
        end
        floor_b = 4'd1;
        door_b  = 1'b1;
        @(negedge clk);
        door_b = 1'b0;
        tests_run++;
        if (outst_b !== 4'd1 || lamps_b !== 16'h000C || req_b !== 4'd0) begin
            tests_failed++;
            $display("FAIL max_out_service1: got out=%0d lamps=%h req=%0d expected 1/000C/0", outst_b, lamps_b, req_b);
        end
        @(negedge clk);
        tests_run++;
        if (req_b !== 4'd3) begin
            tests_failed++;
            $display("FAIL max_out_issue3: got %0d expected 3", req_b);
        end
        @(negedge clk);
        tests_run++;
        if (outst_b !== 4'd2 || req_b !== 4'd0) begin
            tests_failed++;
            $display("FAIL max_out_after3: got out=%0d req=%0d expected 2/0", outst_b, req_b);
        end
        floor_b = 4'd0;
    endtask

    // Door held open at floor 4: a single decrement. A re-press while the
    // door is still open becomes a fresh call.
    task automatic test_door_held();
        logic [15:0] exp_lamps;
        logic [3:0]  exp_req;
        logic [3:0]  exp_out;
        apply_reset();
        buttons[4] = 1'b1;
        step(10);
        buttons[4] = 1'b0;
        step(1);
        tests_run++;
        if (outst !== 4'd1) begin
            tests_failed++;
            $display("FAIL door_setup: got %0d expected 1", outst);
        end
        current_floor = 4'd4;
        door_open     = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            tests_run++;
            if (outst !== 4'd0 || lamps !== 16'h0000) begin
                tests_failed++;
                $display("FAIL door_held k=%0d: got out=%0d lamps=%h expected 0/0000", k, outst, lamps);
            end
        end
        buttons[4] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp_lamps = (k >= 7) ? 16'h0010 : 16'h0000;
            exp_req   = (k == 8) ? 4'd4 : 4'd0;
            exp_out   = (k >= 9) ? 4'd1 : 4'd0;
            tests_run++;
            if (lamps !== exp_lamps || req_floor !== exp_req || outst !== exp_out) begin
                tests_failed++;
                $display("FAIL door_repress k=%0d: got lamps=%h req=%0d out=%0d expected %h/%0d/%0d",
                         k, lamps, req_floor, outst, exp_lamps, exp_req, exp_out);
            end
        end
        buttons       = 16'd0;
        door_open     = 1'b0;
        current_floor = 4'd0;
    endtask

    // A service that lands in the ISSUE cycle of the same floor leaves the
    // floor IDLE with no net change in the count.
    task automatic test_same_cycle();
        apply_reset();
        buttons[6] = 1'b1;
        step(8);
        tests_run++;
        if (req_floor !== 4'd6) begin
            tests_failed++;
            $display("FAIL same_cycle_req: got %0d expected 6", req_floor);
        end
        current_floor = 4'd6;
        door_open     = 1'b1;
        @(negedge clk);
        door_open = 1'b0;
        tests_run++;
        if (lamps !== 16'h0000 || outst !== 4'd0) begin
            tests_failed++;
            $display("FAIL same_cycle_state: got lamps=%h out=%0d expected 0000/0", lamps, outst);
        end
        buttons[6] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            tests_run++;
            if (req_floor !== 4'd0 || lamps !== 16'h0000) begin
                tests_failed++;
                $display("FAIL same_cycle_quiet k=%0d: got req=%0d lamps=%h expected 0/0000", k, req_floor, lamps);
            end
        end
        current_floor = 4'd0;
    endtask

    // Reset during the ISSUE cycle clears req_floor at once. A held button
    // then re-qualifies from scratch.
    task automatic test_reset_mid_issue();
        logic [15:0] exp_lamps;
        logic [3:0]  exp_req;
        apply_reset();
        buttons[7] = 1'b1;
        step(8);
        tests_run++;
        if (req_floor !== 4'd7) begin
            tests_failed++;
            $display("FAIL mid_issue_setup: got %0d expected 7", req_floor);
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (req_floor !== 4'd0 || lamps !== 16'h0000 || outst !== 4'd0) begin
            tests_failed++;
            $display("FAIL mid_issue_async: got req=%0d lamps=%h out=%0d expected 0/0000/0", req_floor, lamps, outst);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_lamps = (k >= 7) ? 16'h0080 : 16'h0000;
            exp_req   = (k == 8) ? 4'd7 : 4'd0;
            tests_run++;
            if (lamps !== exp_lamps || req_floor !== exp_req) begin
                tests_failed++;
                $display("FAIL requalify k=%0d: got lamps=%h req=%0d expected %h/%0d", k, lamps, req_floor, exp_lamps, exp_req);
            end
        end
        buttons = 16'd0;
    endtask

    initial begin
        reset         = 1'b1;
        buttons       = 16'd0;
        current_floor = 4'd0;
        door_open     = 1'b0;
        buttons_b     = 16'd0;
        floor_b       = 4'd0;
        door_b        = 1'b0;

        test_reset();
        test_press_latency();
        test_glitch();
        test_round_robin();
        test_max_outstanding();
        test_door_held();
        test_same_cycle();
        test_reset_mid_issue();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/elevator_call_panel.md
ELEVATOR_CALL_PANEL -- requirements
Module: elevator_call_panel

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized-high cycles (1..31) needed to accept a button press.
REQ-002 Parameter MAX_OUTSTANDING, default 8: maximum issued-but-unserviced calls (1..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 buttons  input  16  raw asynchronous call buttons, bit f = floor f; bit 0 ignored (floor code 0 means "no request").
REQ-006 current_floor  input  4  controller's present floor.
REQ-007 door_open  input  1  controller door-open indication.
REQ-008 req_floor  output  4  floor request to controller, registered; nonzero for exactly one cycle per issued call, 0 otherwise.
REQ-009 call_lamps  output  16  registered; bit f high while floor f call is PENDING or ISSUED; bit 0 always 0.
REQ-010 outstanding  output  4  registered count of ISSUED calls.

Function
REQ-011 Each buttons[f], f=1..15, SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Per-floor debounce counter SHALL increment while synchronized bit is high, saturate at DEBOUNCE_CYCLES, and clear to 0 when the bit is low.
REQ-013 A press event SHALL fire once, in the cycle the counter reaches DEBOUNCE_CYCLES; no further event until the bit goes low and re-qualifies.
REQ-014 Per-floor call state SHALL be one of IDLE, PENDING, ISSUED; call_lamps[f] = (state != IDLE).
REQ-015 Press event on IDLE floor -> PENDING next cycle; press on PENDING or ISSUED floor ignored.
REQ-016 Issuer FSM states: SCAN, ISSUE, GAP.
REQ-017 SCAN: if any floor PENDING and outstanding < MAX_OUTSTANDING, select floor by round-robin starting at (last_issued+1), wrapping 15 -> 1; go ISSUE.
REQ-018 ISSUE: req_floor = selected floor for one cycle; that floor -> ISSUED; outstanding +1; go GAP.
REQ-019 GAP: req_floor = 0 for one cycle; go SCAN. Minimum spacing between nonzero req_floor values therefore 3 cycles.
REQ-020 last_issued SHALL reset to 15 so the first search starts at floor 1.
REQ-021 Service event: rising edge of door_open (registered previous value low, current high) with current_floor = f, f != 0.
REQ-022 Service on ISSUED floor -> IDLE, outstanding -1; on PENDING floor -> IDLE, no count change; on IDLE floor -> no effect.
REQ-023 Service and issue of the same floor in the same cycle: floor ends IDLE, outstanding unchanged net.
REQ-024 Issue and service of different floors same cycle: outstanding unchanged; both state changes applied.
REQ-025 Press event and service event for same floor same cycle: service wins, floor ends IDLE.
REQ-026 outstanding SHALL never exceed MAX_OUTSTANDING nor underflow below 0; at MAX_OUTSTANDING, SCAN stalls with PENDING calls held.
REQ-027 Press-to-lamp latency: lamp high DEBOUNCE_CYCLES+3 cycles after buttons[f] rises (2 sync + counter + state register); earliest req_floor 1 cycle after lamp.

Reset
REQ-028 On reset: req_floor=0, call_lamps=0, outstanding=0, all floors IDLE, debounce counters 0, synchronizers 0, FSM=SCAN, last_issued=15, door_open history 0.
REQ-029 Reset asserted mid-ISSUE SHALL force req_floor to 0 immediately (asynchronously) and discard all calls.
REQ-030 After reset release, buttons held high SHALL re-qualify through full debounce before generating events.

Verification
REQ-031 buttons[5] high 10 cycles -> call_lamps[5] high at cycle 7 after rise; req_floor=5 for exactly one cycle; outstanding=1.
REQ-032 buttons[3] glitch high 3 cycles (DEBOUNCE_CYCLES=4) -> no lamp, req_floor stays 0.
REQ-033 Floors 2,9,14 pressed together, last_issued=9 -> issue order 14, 2, 9, each separated by 3 cycles.
REQ-034 MAX_OUTSTANDING=2, floors 1,2,3 pressed -> 1,2 issued, 3 stays PENDING; door_open rising with current_floor=1 -> lamp1 clears, outstanding 1, then 3 issued.
REQ-035 Issue floor 4, door_open held high at current_floor=4 for 5 cycles -> single decrement, lamp4 clears; re-press of 4 while door still high -> new PENDING, no extra decrement.
REQ-036 Reset pulsed during cycle req_floor=7 -> req_floor 0 same cycle, lamps 0, outstanding 0.
